// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and constants for the UART receive frame path
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Wide enough to hold a bit position 0..data_width inclusive.
    function automatic int cnt_width(input int data_width);
        return $clog2(data_width + 1);
    endfunction

endpackage

// File: rtl/uart_rx_parity_acc.sv
// rtl/uart_rx_parity_acc.sv - running XOR over the data bits of one frame
module uart_rx_parity_acc (
    input  logic rx_clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    input  logic bit_in,
    output logic parity
);

    logic parity_q, parity_d;

    always_comb begin
        parity_d = parity_q;
        if (clear) begin
            parity_d = 1'b0;
        end else if (enable) begin
            parity_d = parity_q ^ bit_in;
        end
    end

    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign parity = parity_q;

endmodule

// File: rtl/uart_rx_frame_check.sv
// rtl/uart_rx_frame_check.sv - UART frame deserialiser with start/parity/stop checking
module uart_rx_frame_check
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  rx_clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic                  bit_strobe,
    input  logic                  sampled_bit,
    input  logic                  par_en,
    input  logic                  par_type,
    input  logic                  stop2,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  stop_error,
    output logic                  start_glitch,
    output logic                  busy
);

    localparam int CW = cnt_width(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_DATA = CW'(DATA_WIDTH - 1);

    rx_state_e             state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  cfg_par_en_q, cfg_par_en_d;
    logic                  cfg_par_type_q, cfg_par_type_d;
    logic                  cfg_stop2_q, cfg_stop2_d;
    logic                  par_flag_q, par_flag_d;
    logic                  stop_flag_q, stop_flag_d;
    logic                  data_valid_q, data_valid_d;
    logic                  parity_error_q, parity_error_d;
    logic                  stop_error_q, stop_error_d;
    logic                  start_glitch_q, start_glitch_d;
    logic                  busy_q, busy_d;
    logic                  frame_accept;
    logic                  data_stb;
    logic                  acc_parity;

    assign frame_accept = (state_q == IDLE) && frame_start;
    assign data_stb     = (state_q == DATA) && bit_strobe;

    uart_rx_parity_acc u_parity_acc (
        .rx_clk (rx_clk),
        .rst_n  (rst_n),
        .clear  (frame_accept),
        .enable (data_stb),
        .bit_in (sampled_bit),
        .parity (acc_parity)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        shift_d        = shift_q;
        p_data_d       = p_data_q;
        cfg_par_en_d   = cfg_par_en_q;
        cfg_par_type_d = cfg_par_type_q;
        cfg_stop2_d    = cfg_stop2_q;
        par_flag_d     = par_flag_q;
        stop_flag_d    = stop_flag_q;
        data_valid_d   = 1'b0;
        parity_error_d = parity_error_q;
        stop_error_d   = stop_error_q;
        start_glitch_d = 1'b0;
        busy_d         = busy_q;

        case (state_q)
            IDLE: begin
                // A strobe coinciding with frame_start belongs to no frame and is dropped.
                if (frame_start) begin
                    state_d        = START;
                    busy_d         = 1'b1;
                    cnt_d          = '0;
                    cfg_par_en_d   = par_en;
                    cfg_par_type_d = par_type;
                    cfg_stop2_d    = stop2;
                    par_flag_d     = 1'b0;
                    stop_flag_d    = 1'b0;
                end
            end
            START: begin
                if (bit_strobe) begin
                    if (sampled_bit) begin
                        state_d        = IDLE;
                        busy_d         = 1'b0;
                        start_glitch_d = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (bit_strobe) begin
                    for (int i = 0; i < DATA_WIDTH; i++) begin
                        if (cnt_q == CW'(i)) begin
                            shift_d[i] = sampled_bit;
                        end
                    end
                    if (cnt_q == LAST_DATA) begin
                        cnt_d   = '0;
                        state_d = cfg_par_en_q ? PARITY : STOP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_strobe) begin
                    par_flag_d = (sampled_bit != (acc_parity ^ cfg_par_type_q));
                    state_d    = STOP;
                end
            end
            STOP: begin
                // cnt_q counts stop bits already taken; a bad first stop bit never skips the second.
                if (bit_strobe) begin
                    if (cfg_stop2_q && (cnt_q == '0)) begin
                        cnt_d       = CW'(1);
                        stop_flag_d = stop_flag_q | ~sampled_bit;
                    end else begin
                        state_d        = IDLE;
                        busy_d         = 1'b0;
                        cnt_d          = '0;
                        data_valid_d   = 1'b1;
                        p_data_d       = shift_q;
                        parity_error_d = cfg_par_en_q & par_flag_q;
                        stop_error_d   = stop_flag_q | ~sampled_bit;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            shift_q        <= '0;
            p_data_q       <= '0;
            cfg_par_en_q   <= 1'b0;
            cfg_par_type_q <= PAR_EVEN;
            cfg_stop2_q    <= 1'b0;
            par_flag_q     <= 1'b0;
            stop_flag_q    <= 1'b0;
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            stop_error_q   <= 1'b0;
            start_glitch_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            shift_q        <= shift_d;
            p_data_q       <= p_data_d;
            cfg_par_en_q   <= cfg_par_en_d;
            cfg_par_type_q <= cfg_par_type_d;
            cfg_stop2_q    <= cfg_stop2_d;
            par_flag_q     <= par_flag_d;
            stop_flag_q    <= stop_flag_d;
            data_valid_q   <= data_valid_d;
            parity_error_q <= parity_error_d;
            stop_error_q   <= stop_error_d;
            start_glitch_q <= start_glitch_d;
            busy_q         <= busy_d;
        end
    end

    assign p_data       = p_data_q;
    assign data_valid   = data_valid_q;
    assign parity_error = parity_error_q;
    assign stop_error   = stop_error_q;
    assign start_glitch = start_glitch_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// tb/tb_uart_rx_frame_check.sv - randomized self-checking bench for uart_rx_frame_check
module tb_uart_rx_frame_check;

    localparam int DW = 8;

    logic          rx_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_start = 1'b0;
    logic          bit_strobe = 1'b0;
    logic          sampled_bit = 1'b0;
    logic          par_en = 1'b0;
    logic          par_type = 1'b0;
    logic          stop2 = 1'b0;
    logic [DW-1:0] p_data;
    logic          data_valid;
    logic          parity_error;
    logic          stop_error;
    logic          start_glitch;
    logic          busy;

    int checks = 0;
    int failures = 0;
    int dv_seen = 0;
    int dv_exp = 0;

    // Frame-level reference state: what the last completed frame must have produced.
    logic [DW-1:0] m_data = '0;
    logic          m_perr = 1'b0;
    logic          m_serr = 1'b0;

    always #5 rx_clk = ~rx_clk;

    uart_rx_frame_check #(.DATA_WIDTH(DW)) dut (
        .rx_clk       (rx_clk),
        .rst_n        (rst_n),
        .frame_start  (frame_start),
        .bit_strobe   (bit_strobe),
        .sampled_bit  (sampled_bit),
        .par_en       (par_en),
        .par_type     (par_type),
        .stop2        (stop2),
        .p_data       (p_data),
        .data_valid   (data_valid),
        .parity_error (parity_error),
        .stop_error   (stop_error),
        .start_glitch (start_glitch),
        .busy         (busy)
    );

    always @(negedge rx_clk) begin
        if (data_valid) dv_seen++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge rx_clk);
        #1;
    endtask

    task automatic strobe(input logic b, input int gap, input bit mess_cfg);
        for (int i = 0; i < gap; i++) begin
            if (mess_cfg) begin
                par_en   = 1'($urandom);
                par_type = 1'($urandom);
                stop2    = 1'($urandom);
            end
            tick();
        end
        bit_strobe  = 1'b1;
        sampled_bit = b;
        tick();
        bit_strobe  = 1'b0;
        sampled_bit = 1'($urandom);
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_pdata"}, 32'(p_data), 32'(m_data));
        check_eq({tag, "_perr"}, 32'(parity_error), 32'(m_perr));
        check_eq({tag, "_serr"}, 32'(stop_error), 32'(m_serr));
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic pe, input logic pt, input logic s2,
                              input logic start_b, input logic pbit, input logic s1b, input logic s2b,
                              input int maxgap, input bit same_cycle_strobe);
        par_en      = pe;
        par_type    = pt;
        stop2       = s2;
        frame_start = 1'b1;
        if (same_cycle_strobe) begin
            bit_strobe  = 1'b1;
            sampled_bit = 1'b1;
        end
        tick();
        frame_start = 1'b0;
        bit_strobe  = 1'b0;
        check_eq("busy_rise", 32'(busy), 1);

        strobe(start_b, $urandom_range(0, maxgap), 1'b1);
        if (start_b) begin
            check_eq("glitch_pulse", 32'(start_glitch), 1);
            check_eq("glitch_busy", 32'(busy), 0);
            check_eq("glitch_no_dv", 32'(data_valid), 0);
            check_outputs("glitch_hold");
            tick();
            check_eq("glitch_single", 32'(start_glitch), 0);
            return;
        end
        check_eq("start_busy", 32'(busy), 1);

        for (int i = 0; i < DW; i++) begin
            strobe(d[i], $urandom_range(0, maxgap), 1'b1);
            check_eq("data_no_dv", 32'(data_valid), 0);
        end
        if (pe) begin
            strobe(pbit, $urandom_range(0, maxgap), 1'b1);
            check_eq("par_no_dv", 32'(data_valid), 0);
        end
        if (s2) begin
            strobe(s1b, $urandom_range(0, maxgap), 1'b1);
            check_eq("stop1_no_dv", 32'(data_valid), 0);
            strobe(s2b, $urandom_range(0, maxgap), 1'b1);
        end else begin
            strobe(s1b, $urandom_range(0, maxgap), 1'b1);
        end

        // Reference: even parity means data plus parity bit has an even count of ones.
        m_data = d;
        m_perr = pe && (((^d) ^ pbit) != pt);
        m_serr = (s1b == 1'b0) || (s2 && (s2b == 1'b0));
        dv_exp++;
        check_eq("dv_pulse", 32'(data_valid), 1);
        check_eq("done_busy", 32'(busy), 0);
        check_outputs("done");
    endtask

    initial begin
        tick();
        tick();
        check_eq("rst_pdata", 32'(p_data), 0);
        check_eq("rst_dv", 32'(data_valid), 0);
        check_eq("rst_perr", 32'(parity_error), 0);
        check_eq("rst_serr", 32'(stop_error), 0);
        check_eq("rst_glitch", 32'(start_glitch), 0);
        check_eq("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        tick();

        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0);
        check_eq("a5_perr_clean", 32'(parity_error), 0);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1, 1'b0);
        check_eq("a5_perr_bad", 32'(parity_error), 1);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        check_eq("3c_perr_clear", 32'(parity_error), 0);
        send_frame(8'h0F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        check_eq("0f_serr", 32'(stop_error), 1);
        tick();
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1'b0);

        // Stray strobe while idle must not start anything.
        strobe(1'b1, 1, 1'b0);
        check_eq("idle_strobe_busy", 32'(busy), 0);
        check_eq("idle_strobe_glitch", 32'(start_glitch), 0);

        // Abort with reset after the fourth data bit.
        par_en      = 1'b1;
        par_type    = 1'b1;
        stop2       = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        strobe(1'b0, 0, 1'b0);
        for (int i = 0; i < 4; i++) strobe(1'($urandom), 1, 1'b0);
        rst_n = 1'b0;
        #1;
        m_data = '0;
        m_perr = 1'b0;
        m_serr = 1'b0;
        check_outputs("async_rst");
        check_eq("async_rst_busy", 32'(busy), 0);
        check_eq("async_rst_dv", 32'(data_valid), 0);
        tick();
        rst_n = 1'b1;
        tick();
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0);

        // Back-to-back frames with config lines churning mid-frame.
        send_frame(8'hC3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2, 1'b0);
        send_frame(8'h96, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2, 1'b1);

        for (int n = 0; n < 40; n++) begin
            logic [DW-1:0] d;
            logic          sb;
            d  = DW'($urandom);
            sb = ($urandom_range(0, 7) == 0);
            send_frame(d, 1'($urandom), 1'($urandom), 1'($urandom), sb, 1'($urandom),
                       ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), 2,
                       ($urandom_range(0, 4) == 0));
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
        end

        tick();
        check_eq("dv_count", 32'(dv_seen), 32'(dv_exp));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
